// File: rtl/l1_tgv_ctrl_if.sv
// Signal bundle between the L1 tag+valid controller, the CPU side, the refill
// path and the tag array. The controller uses the slave view; its environment uses the master view.
interface l1_tgv_ctrl_if #(
  parameter int TAG_WIDTH = 9,
  parameter int IDX_WIDTH = 6,
  parameter int OFF_WIDTH = 4
);
  localparam int ADDR_WIDTH = TAG_WIDTH + IDX_WIDTH + OFF_WIDTH;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  resp_valid_o;
  logic                  resp_hit_o;
  logic                  fill_req_valid_o;
  logic                  fill_req_ready_i;
  logic [ADDR_WIDTH-1:0] fill_req_addr_o;
  logic                  fill_done_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  tgv_we_o;
  logic [IDX_WIDTH-1:0]  tgv_addr_o;
  logic [TAG_WIDTH:0]    tgv_data_o;
  logic [TAG_WIDTH:0]    tgv_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, fill_req_ready_i, fill_done_i, flush_i, tgv_data_i,
    output req_ready_o, resp_valid_o, resp_hit_o, fill_req_valid_o, fill_req_addr_o,
           busy_o, tgv_we_o, tgv_addr_o, tgv_data_o
  );

  modport master (
    output req_valid_i, req_addr_i, fill_req_ready_i, fill_done_i, flush_i, tgv_data_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, fill_req_valid_o, fill_req_addr_o,
           busy_o, tgv_we_o, tgv_addr_o, tgv_data_o
  );
endinterface

// File: rtl/l1_tgv_ctrl.sv
// Lookup/refill controller for the L1 data cache tag+valid array (read-first,
// 1-cycle-latency RAM): hit/miss detection, refill request, tag install, clear-all.
module l1_tgv_ctrl #(
  parameter int TAG_WIDTH = 9,
  parameter int IDX_WIDTH = 6,
  parameter int OFF_WIDTH = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  l1_tgv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    UPDATE
  } state_t;

  state_t               state, state_d;
  logic [IDX_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 accept;
  logic                 hit;
  logic                 unused_off;

  assign req_idx    = bus.req_addr_i[OFF_WIDTH +: IDX_WIDTH];
  assign req_tag    = bus.req_addr_i[OFF_WIDTH+IDX_WIDTH +: TAG_WIDTH];
  assign unused_off = ^bus.req_addr_i[OFF_WIDTH-1:0];

  // Read data belongs to the index presented in the accepting IDLE cycle.
  assign hit    = bus.tgv_data_i[0] && (bus.tgv_data_i[TAG_WIDTH:1] == tag_q);
  assign bus.busy_o = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT;
      cnt   <= '0;
      idx_q <= '0;
      tag_q <= '0;
    end else begin
      state <= state_d;
      // The clear counter only runs in INIT; elsewhere it rests at zero so a
      // flush always restarts the sweep from entry 0.
      cnt <= (state == INIT) ? cnt + IDX_WIDTH'(1) : '0;
      if (accept) begin
        idx_q <= req_idx;
        tag_q <= req_tag;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d              = state;
    accept               = 1'b0;
    bus.req_ready_o      = 1'b0;
    bus.resp_valid_o     = 1'b0;
    bus.resp_hit_o       = 1'b0;
    bus.fill_req_valid_o = 1'b0;
    bus.fill_req_addr_o  = '0;
    bus.tgv_we_o         = 1'b0;
    bus.tgv_addr_o       = idx_q;
    bus.tgv_data_o       = '0;

    unique case (state)
      INIT: begin
        bus.tgv_we_o   = 1'b1;
        bus.tgv_addr_o = cnt;
        if (&cnt) state_d = IDLE;
      end
      IDLE: begin
        bus.tgv_addr_o  = req_idx;
        bus.req_ready_o = !bus.flush_i;
        if (bus.flush_i) begin
          state_d = INIT;
        end else if (bus.req_valid_i) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          bus.resp_valid_o = 1'b1;
          bus.resp_hit_o   = 1'b1;
          state_d          = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        bus.fill_req_valid_o = 1'b1;
        bus.fill_req_addr_o  = {tag_q, idx_q, {OFF_WIDTH{1'b0}}};
        if (bus.fill_req_ready_i) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        // Only reachable after the handshake, so a done pulse coincident with
        // the handshake is never seen here.
        if (bus.fill_done_i) state_d = UPDATE;
      end
      UPDATE: begin
        bus.tgv_we_o     = 1'b1;
        bus.tgv_data_o   = {tag_q, 1'b1};
        bus.resp_valid_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

endmodule

// File: tb/tb_l1_tgv_ctrl.sv
// Self-checking bench for l1_tgv_ctrl: tag RAM model, cache-map reference model,
// scoreboard queues checked by a decoupled response monitor and refill responder.
module tb_l1_tgv_ctrl;
  localparam int TW = 9;
  localparam int IW = 6;
  localparam int OW = 4;
  localparam int AW = TW + IW + OW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_tgv_ctrl_if #(.TAG_WIDTH(TW), .IDX_WIDTH(IW), .OFF_WIDTH(OW)) bus ();

  l1_tgv_ctrl #(.TAG_WIDTH(TW), .IDX_WIDTH(IW), .OFF_WIDTH(OW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ready_dly = -1;
  int done_dly  = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous tag array.
  logic [TW:0] mem [0:(1<<IW)-1];
  always @(posedge clk) begin
    bus.tgv_data_i <= mem[bus.tgv_addr_o];
    if (bus.tgv_we_o) mem[bus.tgv_addr_o] <= bus.tgv_data_o;
  end

  // Reference: which block each set currently holds.
  bit          ref_valid [0:(1<<IW)-1];
  logic [TW-1:0] ref_tag [0:(1<<IW)-1];
  bit          exp_resp [$];
  logic [AW-1:0] exp_fill [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_clear();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
  endfunction

  function automatic bit predict(input logic [AW-1:0] addr);
    int            idx = int'(addr[OW +: IW]);
    logic [TW-1:0] tag = addr[OW+IW +: TW];
    bit            h   = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_resp.push_back(h);
    if (!h) begin
      exp_fill.push_back({tag, addr[OW +: IW], {OW{1'b0}}});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    return h;
  endfunction

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid_o) begin
      if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp_hit", 32'(bus.resp_hit_o), 32'(exp_resp.pop_front()));
    end
  end

  // Refill responder: random (or forced) ready stall, then a later done pulse.
  initial begin
    logic [AW-1:0] a0;
    int d;
    bit aborted;
    bus.fill_req_ready_i = 1'b0;
    bus.fill_done_i      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.fill_req_valid_o) begin
        a0 = bus.fill_req_addr_o;
        d  = (ready_dly < 0) ? int'($urandom_range(0, 3)) : ready_dly;
        aborted = 1'b0;
        for (int k = 0; k < d; k++) begin
          check("fill_valid_held", 32'(bus.fill_req_valid_o), 1);
          check("fill_addr_stable", 32'(bus.fill_req_addr_o), 32'(a0));
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
          if (exp_fill.size() == 0) check("fill_unexpected", 1, 0);
          else check("fill_addr", 32'(bus.fill_req_addr_o), 32'(exp_fill.pop_front()));
          bus.fill_req_ready_i = 1'b1;
          @(negedge clk);
          bus.fill_req_ready_i = 1'b0;
          d = (done_dly < 0) ? int'($urandom_range(0, 4)) : done_dly;
          for (int k = 0; k < d; k++) begin
            if (rst) begin aborted = 1'b1; break; end
            @(negedge clk);
          end
          if (!aborted && !rst) begin
            bus.fill_done_i = 1'b1;
            @(negedge clk);
            bus.fill_done_i = 1'b0;
          end
        end
      end
    end
  end

  // Expects the 64-cycle clear sweep starting in the current cycle.
  task automatic check_init();
    for (int i = 0; i < (1 << IW); i++) begin
      check($sformatf("init_cycle_%0d", i),
            32'({bus.tgv_we_o, bus.req_ready_o, bus.tgv_addr_o, bus.tgv_data_o}),
            32'({1'b1, 1'b0, 6'(i), 10'h0}));
      @(negedge clk);
    end
    check("init_done_ready_busy", 32'({bus.req_ready_o, bus.busy_o, bus.tgv_we_o}), 32'(3'b100));
  endtask

  task automatic do_req(input logic [AW-1:0] addr, input bit wait_resp,
                        output int lat, output bit hit_pred);
    bit accepted = 1'b0;
    bit got = 1'b0;
    int acc = 0;
    lat = 0;
    hit_pred = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    for (int k = 0; k < 300 && !accepted; k++) begin
      if (bus.req_ready_o) begin
        acc = cyc;
        hit_pred = predict(addr);
        accepted = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = AW'($urandom);
    check("req_accept_timeout", 32'(accepted), 1);
    if (accepted && wait_resp) begin
      for (int k = 0; k < 400 && !got; k++) begin
        if (bus.resp_valid_o) begin
          got = 1'b1;
          lat = cyc - acc + 1;
        end else begin
          @(negedge clk);
        end
      end
      check("resp_timeout", 32'(got), 1);
    end
  endtask

  task automatic do_flush();
    bit got = 1'b0;
    bus.flush_i = 1'b1;
    ref_clear();
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (bus.tgv_we_o && bus.tgv_data_o == '0) got = 1'b1;
    end
    bus.flush_i = 1'b0;
    check("flush_timeout", 32'(got), 1);
    if (got) begin
      check("flush_after_resp", 32'(exp_resp.size()), 0);
      check_init();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit hp;
    bit seen;
    logic [TW-1:0] tags [4];
    logic [IW-1:0] idxs [4];
    tags = '{9'h048, 9'h049, 9'h0A5, 9'h013};
    idxs = '{6'h34, 6'h00, 6'h01, 6'h3F};

    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.flush_i     = 1'b0;
    // Stale valid entries: only the clear sweep stops them from hitting.
    for (int i = 0; i < (1 << IW); i++) mem[i] = {9'h1FF, 1'b1};
    mem[6'h34] = {9'h048, 1'b1};
    ref_clear();

    repeat (3) @(negedge clk);
    check("rst_flags", 32'({bus.req_ready_o, bus.resp_valid_o, bus.resp_hit_o,
                             bus.fill_req_valid_o, bus.busy_o, bus.tgv_we_o}), 32'(6'b000011));
    check("rst_fill_addr", 32'(bus.fill_req_addr_o), 0);
    check("rst_tgv_addr_data", 32'({bus.tgv_addr_o, bus.tgv_data_o}), 0);
    rst = 1'b0;
    #1;
    check_init();

    // Cold miss, then install check.
    do_req(19'h12345, 1'b1, lat, hp);
    @(negedge clk);
    check("t2_entry_34", 32'(mem[6'h34]), 32'h091);

    // Repeat to the same block: hit in acceptance cycle + LOOKUP cycle.
    do_req(19'h1234C, 1'b1, lat, hp);
    check("t3_hit_latency", 32'(lat), 2);
    @(negedge clk);

    // Conflicting tag, refill request stalled for 5 cycles.
    ready_dly = 5;
    do_req(19'h12740, 1'b1, lat, hp);
    ready_dly = -1;
    @(negedge clk);
    check("t4_entry_34", 32'(mem[6'h34]), 32'h093);

    // Flush raised during a miss: miss completes first, then the sweep.
    ready_dly = 3;
    done_dly  = 5;
    do_req(19'h00010, 1'b0, lat, hp);
    do_flush();
    ready_dly = -1;
    done_dly  = -1;
    do_req(19'h12740, 1'b1, lat, hp);
    @(negedge clk);

    // Reset while waiting for the refill to complete.
    done_dly = 30;
    do_req(19'h12340, 1'b0, lat, hp);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.fill_req_valid_o) seen = 1'b1;
      else if (seen) break;
      @(negedge clk);
    end
    check("t6_reached_wait", 32'({seen, bus.fill_req_valid_o, bus.busy_o}), 32'(3'b101));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_flags", 32'({bus.req_ready_o, bus.resp_valid_o, bus.fill_req_valid_o,
                                bus.busy_o, bus.tgv_we_o}), 32'(5'b00011));
    check("t6_rst_tgv", 32'({bus.tgv_addr_o, bus.tgv_data_o, bus.fill_req_addr_o}), 0);
    ref_clear();
    exp_resp.delete();
    exp_fill.delete();
    done_dly = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_init();
    do_req(19'h12340, 1'b1, lat, hp);
    @(negedge clk);

    // Randomized traffic over a small tag/index set to mix hits and misses.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush();
      end else begin
        do_req({tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 4'($urandom)},
               1'b1, lat, hp);
        if (hp) check("rand_hit_latency", 32'(lat), 2);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_resp.size() + exp_fill.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
